// File: rtl/dm_stage_mem.sv
// dm_stage_mem: data-memory pipeline stage with post-reset RAM clear, stall handshake
// and sticky out-of-range flag; one registered write-back record per accepted instruction.
module dm_stage_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RID_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              stall,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [RID_W-1:0]  rd,
    output logic              out_valid,
    output logic              wb_en,
    output logic [RID_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              addr_err,
    output logic              init_busy
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [3:0] OP_LOAD = 4'hD, OP_STORE = 4'hE, OP_LOADIMM = 4'hF;

    typedef enum logic {INIT, RUN} state_t;

    state_t state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic out_valid_q, out_valid_d, wb_en_q, wb_en_d, addr_err_q, addr_err_d;
    logic [RID_W-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [DATA_W-1:0] ram [DEPTH];
    logic accept, in_range, is_mem, ram_we;
    logic [PW-1:0] ram_idx;
    logic [DATA_W-1:0] ram_wdata, rd_word;

    assign in_ready  = (state_q == RUN) && !stall;
    assign init_busy = (state_q == INIT);
    assign out_valid = out_valid_q;
    assign wb_en     = wb_en_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign addr_err  = addr_err_q;

    always_comb begin
        accept    = in_valid && in_ready;
        in_range  = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
        is_mem    = (opcode == OP_LOAD) || (opcode == OP_STORE);
        rd_word   = ram[addr[PW-1:0]];
        state_d   = state_q;
        ptr_d     = ptr_q;
        ram_we    = 1'b0;
        ram_idx   = ptr_q;
        ram_wdata = '0;
        out_valid_d = out_valid_q;
        wb_en_d   = wb_en_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        addr_err_d = addr_err_q || (accept && is_mem && !in_range);
        if (state_q == INIT) begin
            ram_we  = 1'b1;
            ptr_d   = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
            state_d = (ptr_q == PW'(DEPTH - 1)) ? RUN : INIT;
        end
        if (!stall) begin
            out_valid_d = accept;
            wb_en_d     = accept && (opcode != OP_STORE);
        end
        if (accept) begin
            wb_rd_d   = rd;
            wb_data_d = (opcode == OP_LOAD)    ? (in_range ? rd_word : '0) :
                        (opcode == OP_STORE)   ? '0 :
                        (opcode == OP_LOADIMM) ? DATA_W'(addr) : alu_result;
            if (opcode == OP_STORE && in_range) begin
                ram_we    = 1'b1;
                ram_idx   = addr[PW-1:0];
                ram_wdata = alu_result;
            end
        end
        if (rst) ram_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // RAM has no reset; only the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= ram_wdata;
    end
endmodule

// File: tb/tb_dm_stage_mem.sv
// tb_dm_stage_mem: directed vectors with a scoreboard queue and an independent output monitor.
module tb_dm_stage_mem;
    localparam logic [3:0] LOAD = 4'hD, STORE = 4'hE, LDI = 4'hF;

    logic clk = 1'b0, rst, in_valid, in_ready, stall;
    logic [3:0] opcode;
    logic [7:0] addr, alu_result, wb_data;
    logic [1:0] rd, wb_rd;
    logic out_valid, wb_en, addr_err, init_busy;
    logic st_e, rs_e;
    int checks = 0, failures = 0;

    typedef struct {
        logic       en;
        logic [1:0] rd;
        logic [7:0] data;
        logic       err;
    } rec_t;
    rec_t q[$];

    always #5 clk = ~clk;

    dm_stage_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .RID_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
        .opcode(opcode), .addr(addr), .alu_result(alu_result), .rd(rd),
        .out_valid(out_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .addr_err(addr_err), .init_busy(init_busy)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        st_e <= stall;
        rs_e <= rst;
    end

    always @(negedge clk) begin
        if (out_valid === 1'b1 && st_e === 1'b0 && rs_e === 1'b0) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                rec_t e;
                e = q.pop_front();
                chk("sb_wb_en", wb_en, e.en);
                chk("sb_wb_rd", wb_rd, e.rd);
                chk("sb_wb_data", wb_data, e.data);
                chk("sb_addr_err", addr_err, e.err);
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] d,
                        input logic [1:0] r, input logic en, input logic [7:0] ed, input logic er);
        rec_t e;
        in_valid = 1'b1; opcode = op; addr = a; alu_result = d; rd = r;
        @(posedge clk);
        e.en = en; e.rd = r; e.data = ed; e.err = er;
        q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_reset();
        int n;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_init_busy", init_busy, 1);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("init_cycles", n, 16);
        chk("ready_after_init", in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; stall = 1'b0;
        opcode = '0; addr = '0; alu_result = '0; rd = '0;
        @(posedge clk);
        #1 do_reset();
        for (int i = 0; i < 16; i++) send(LOAD, 8'(i), 8'h00, 2'(i), 1'b1, 8'h00, 1'b0);
        send(STORE, 8'h07, 8'hA5, 2'd0, 1'b0, 8'h00, 1'b0);
        send(LOAD, 8'h07, 8'h00, 2'd2, 1'b1, 8'hA5, 1'b0);
        send(4'b0011, 8'h00, 8'h3C, 2'd1, 1'b1, 8'h3C, 1'b0);
        send(LDI, 8'h5F, 8'h00, 2'd3, 1'b1, 8'h5F, 1'b0);
        send(STORE, 8'h04, 8'h11, 2'd1, 1'b0, 8'h00, 1'b0);
        send(LOAD, 8'h04, 8'h00, 2'd0, 1'b1, 8'h11, 1'b0);
        send(STORE, 8'h05, 8'h21, 2'd1, 1'b0, 8'h00, 1'b0);
        in_valid = 1'b1; opcode = STORE; addr = 8'h06; alu_result = 8'h22; rd = 2'd2; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            chk("stall_out_valid", out_valid, 1);
            chk("stall_wb_en", wb_en, 0);
            chk("stall_wb_rd", wb_rd, 1);
            chk("stall_wb_data", wb_data, 0);
        end
        stall = 1'b0;
        send(STORE, 8'h06, 8'h22, 2'd2, 1'b0, 8'h00, 1'b0);
        send(LOAD, 8'h06, 8'h00, 2'd0, 1'b1, 8'h22, 1'b0);
        send(LOAD, 8'h05, 8'h00, 2'd3, 1'b1, 8'h21, 1'b0);
        send(STORE, 8'd20, 8'hFF, 2'd0, 1'b0, 8'h00, 1'b1);
        send(LOAD, 8'd20, 8'h00, 2'd1, 1'b1, 8'h00, 1'b1);
        send(LOAD, 8'h04, 8'h00, 2'd2, 1'b1, 8'h11, 1'b1);
        repeat (3) @(posedge clk);
        #1 chk("addr_err_sticky", addr_err, 1);
        chk("idle_out_valid", out_valid, 0);
        send(4'b0001, 8'h00, 8'h77, 2'd3, 1'b1, 8'h77, 1'b1);
        chk("run_out_valid_before_rst", out_valid, 1);
        do_reset();
        send(LOAD, 8'h07, 8'h00, 2'd1, 1'b1, 8'h00, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (9) @(posedge clk);
        #1 chk("mid_init_busy", init_busy, 1);
        do_reset();
        send(LOAD, 8'h04, 8'h00, 2'd2, 1'b1, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dm_stage_mem.md
# dm_stage_mem

Parametrised data-memory pipeline stage for the RISC CPU, sitting between the execute stage and register write-back. It executes STORE, LOAD and LOADIMM against an internal synchronous RAM and passes ALU results through. It produces one registered write-back record per accepted instruction. Unlike the previous fixed 8-bit stage, it adds configurable width and depth, a stall/ready handshake, a post-reset RAM clear sequencer, and an out-of-range address error flag.

## Interface
Parameters:
- DATA_W, 8, data word width
- ADDR_W, 8, address width
- DEPTH, 256, number of RAM words; must be ≤ 2**ADDR_W
- RID_W, 2, destination register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  instruction present on inputs
- in_ready  out  1  stage accepts input this cycle
- stall  in  1  downstream hold request
- opcode  in  4  instruction opcode
- addr  in  ADDR_W  memory address, or immediate for LOADIMM
- alu_result  in  DATA_W  ALU output; also the store data
- rd  in  RID_W  destination register index
- out_valid  out  1  write-back record valid
- wb_en  out  1  register file write enable
- wb_rd  out  RID_W  write-back register index
- wb_data  out  DATA_W  write-back data
- addr_err  out  1  sticky out-of-range access flag
- init_busy  out  1  RAM clear sequence in progress

## Operation
- FSM states: INIT, RUN. rst forces INIT with the clear pointer at 0.
- INIT:
  - Writes 0 to RAM[ptr] each cycle and increments ptr.
  - Moves to RUN on the cycle ptr == DEPTH-1 is written.
  - Lasts exactly DEPTH cycles. init_busy=1 and in_ready=0 throughout.
- RUN:
  - in_ready = !stall.
  - An instruction is accepted when in_valid && in_ready.
- Behaviour of an accepted instruction, by opcode:
  - 0000–1100 (ALU ops): wb_data=alu_result, wb_en=1.
  - 1101 LOAD: wb_data=RAM[addr], wb_en=1.
  - 1110 STORE: RAM[addr]←alu_result at the acceptance edge. wb_en=0, wb_data=0.
  - 1111 LOADIMM: wb_data = addr, zero-extended or truncated to DATA_W. wb_en=1.
- For every accepted instruction: wb_rd=rd and out_valid=1 on the next cycle.
- Out-of-range access (addr ≥ DEPTH on LOAD or STORE):
  - STORE is dropped.
  - LOAD returns 0 with wb_en=1.
  - addr_err is set and stays set until rst.
- Cycle with no acceptance while stall=0: out_valid=0 and wb_en=0; wb_data and wb_rd hold their values.
- stall=1: all outputs hold, RAM is not written, no input is accepted.
- Upstream must hold opcode/addr/alu_result/rd stable while in_valid && !in_ready.

## Timing
- Reset values (cycle after rst sampled high): out_valid=0, wb_en=0, wb_rd=0, wb_data=0, addr_err=0, init_busy=1, in_ready=0.
- RAM contents are not cleared by rst itself; they are cleared only by the INIT sweep.
- Latency is 1 cycle: inputs accepted at edge N appear on outputs after edge N.
- Throughput is 1 instruction per cycle when stall=0.
- RAM is a synchronous read/write single-port array. STORE at edge N followed by LOAD of the same address at edge N+1 returns the new data.
- rst asserted mid-INIT restarts the sweep at ptr=0.
- rst asserted mid-RUN discards the in-flight output and re-enters INIT.
- stall and rst asserted together: rst wins.
- stall asserted in the same cycle as in_valid: the instruction is not accepted; in_ready=0 combinationally.
- First acceptance is possible on the cycle after init_busy falls: DEPTH+1 cycles after rst deasserts.

## Test plan
- Reset/init:
  - Stimulus: DEPTH=16, deassert rst.
  - Required: init_busy=1 for exactly 16 cycles, then in_ready=1.
  - Then LOAD from every address 0..15; each returns wb_data=0.
- Store/load back-to-back:
  - Stimulus: STORE alu_result=0xA5 to addr=0x07, then LOAD addr=0x07 with rd=2 on the next cycle.
  - Required: wb_data=0xA5, wb_rd=2, wb_en=1, one cycle after the LOAD is accepted.
- ALU pass and LOADIMM:
  - Stimulus: opcode 0011 with alu_result=0x3C, rd=1; then LOADIMM with addr=0x5F, rd=3.
  - Required: wb_data=0x3C then 0x5F on consecutive cycles, out_valid=1 both cycles.
  - STORE in the same sequence produces wb_en=0.
- Stall:
  - Stimulus: stall=1 for 3 cycles during a stream of STOREs.
  - Required: outputs frozen, in_ready=0, no RAM write occurs.
  - The held instruction is accepted on the first cycle after stall=0.
- Out-of-range:
  - Stimulus: DEPTH=16, STORE 0xFF to addr=20, then LOAD addr=20.
  - Required: LOAD gives wb_data=0 and addr_err=1, which stays 1 until rst.
  - RAM[4] remains unchanged.
- Reset mid-operation:
  - Stimulus: assert rst during INIT at ptr=9, and separately during RUN with out_valid=1.
  - Required: both cases give reset values on the next cycle and a full DEPTH-cycle INIT.
